// File: rtl/debounced_down_counter_pkg.sv
// ============================================================================
// counter_pkg: shared types and helpers for the debounced down counter.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package counter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

  // Out-of-range load values saturate at the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] modulus);
    logic [31:0] result;
    result = (value >= modulus) ? (modulus - 32'd1) : value;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounced_down_counter_if.sv
// ============================================================================
// debounced_down_counter_if: button, load and count signals of the counter.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface debounced_down_counter_if #(
  parameter int WIDTH = 3
);
  logic             step_btn;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             borrow;
  logic             zero;
  logic             step_pulse;

  modport master (
    output step_btn, load, load_value,
    input  count, borrow, zero, step_pulse
  );

  modport slave (
    input  step_btn, load, load_value,
    output count, borrow, zero, step_pulse
  );
endinterface

`default_nettype wire

// File: rtl/debounced_down_counter_button_debouncer.sv
// ============================================================================
// button_debouncer: synchroniser plus debounce FSM, one pulse per clean press.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module button_debouncer
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic step_pulse
);

  localparam int STAB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  deb_state_t             state_q, state_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      stab_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], btn_raw};
    state_d    = state_q;
    stab_d     = stab_q;
    step_pulse = 1'b0;
    btn_level  = (state_q == HELD) || (state_q == RELEASE_WAIT);

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          stab_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d    = HELD;
          stab_d     = '0;
          step_pulse = 1'b1;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          stab_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = IDLE;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        stab_d  = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/debounced_down_counter.sv
// ============================================================================
// debounced_down_counter: loadable modulo-N down counter stepped by a button.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module debounced_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int MODULUS         = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  debounced_down_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             step_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (bus.step_btn),
    .btn_level  (),
    .step_pulse (step_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= TOP_VAL;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
    end
  end

  // Load wins over a coincident step; the step is simply lost.
  always_comb begin
    count_d  = count_q;
    borrow_d = 1'b0;
    if (bus.load) begin
      count_d = WIDTH'(clamp_load(32'(bus.load_value), 32'(MODULUS)));
    end else if (step_pulse) begin
      if (count_q == '0) begin
        count_d  = TOP_VAL;
        borrow_d = 1'b1;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.borrow     = borrow_q;
  assign bus.zero       = (count_q == '0);
  assign bus.step_pulse = step_pulse;

endmodule

`default_nettype wire

// File: tb/tb_debounced_down_counter.sv
// ============================================================================
// tb_debounced_down_counter: directed scenarios plus random run against a model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_debounced_down_counter;

  localparam int W   = 3;
  localparam int MOD = 6;
  localparam int DEB = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  debounced_down_counter_if #(.WIDTH(W)) bus ();

  debounced_down_counter #(
    .WIDTH           (W),
    .MODULUS         (MOD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the accepted level flips once the synchronised input has
  // disagreed with it for DEB+1 consecutive cycles; a 0->1 flip is a press.
  int m_count;
  int m_borrow;
  int m_pulse;
  int m_level;
  int m_run;
  int m_sync1;
  int m_s;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count  = MOD - 1;
      m_borrow = 0;
      m_pulse  = 0;
      m_level  = 0;
      m_run    = 0;
      m_sync1  = 0;
      m_s      = 0;
    end else begin
      m_borrow = 0;
      if (bus.load) begin
        m_count = (int'(bus.load_value) >= MOD) ? MOD - 1 : int'(bus.load_value);
      end else if (m_pulse != 0) begin
        if (m_count == 0) begin
          m_count  = MOD - 1;
          m_borrow = 1;
        end else begin
          m_count = m_count - 1;
        end
      end
      m_s     = m_sync1;
      m_sync1 = int'(bus.step_btn);
      if (m_s != m_level) m_run = m_run + 1;
      else                m_run = 0;
      m_pulse = 0;
      if (m_run == DEB + 1) begin
        m_level = (m_level == 0) ? 1 : 0;
        m_run   = 0;
        m_pulse = m_level;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.count !== 3'd5) begin
      failures++;
      $display("FAIL reset_count actual=%0d required=5", bus.count);
    end
    reset = 1'b1;
    bus.load = 1'b1;
    bus.load_value = 3'd2;
    @(negedge clk);
    bus.load = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd5 || bus.zero !== 1'b0 || bus.borrow !== 1'b0 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL async_reset actual count=%0d zero=%b borrow=%b pulse=%b required 5/0/0/0",
               bus.count, bus.zero, bus.borrow, bus.step_pulse);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.count !== 3'd5 || bus.step_pulse !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d actual count=%0d pulse=%b required 5/0", i, bus.count, bus.step_pulse);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses;
    pulses = 0;
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.step_pulse === 1'b1) pulses++;
      checks++;
      if (bus.step_pulse !== (i == 6) || bus.count !== ((i <= 6) ? 3'd5 : 3'd4)) begin
        failures++;
        $display("FAIL clean_press cycle=%0d actual pulse=%b count=%0d required pulse=%b count=%0d",
                 i, bus.step_pulse, bus.count, (i == 6), (i <= 6) ? 5 : 4);
      end
    end
    bus.step_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.step_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.count !== 3'd4) begin
      failures++;
      $display("FAIL clean_press_total actual pulses=%0d count=%0d required 1/4", pulses, bus.count);
    end
  endtask

  task automatic test_bounce();
    for (int i = 1; i <= 16; i++) begin
      bus.step_btn = (i <= 4) ? ((i % 2) == 1) : 1'b1;
      @(negedge clk);
      checks++;
      if (bus.step_pulse !== (i == 10) || bus.count !== ((i <= 10) ? 3'd4 : 3'd3)) begin
        failures++;
        $display("FAIL bounce cycle=%0d actual pulse=%b count=%0d required pulse=%b count=%0d",
                 i, bus.step_pulse, bus.count, (i == 10), (i <= 10) ? 4 : 3);
      end
    end
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wrap();
    bus.load = 1'b1;
    bus.load_value = 3'd0;
    @(negedge clk);
    bus.load = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL wrap_load actual count=%0d zero=%b required 0/1", bus.count, bus.zero);
    end
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (bus.borrow !== (i == 7) || bus.zero !== (i <= 6) || bus.count !== ((i <= 6) ? 3'd0 : 3'd5)) begin
        failures++;
        $display("FAIL wrap cycle=%0d actual borrow=%b zero=%b count=%0d required borrow=%b zero=%b count=%0d",
                 i, bus.borrow, bus.zero, bus.count, (i == 7), (i <= 6), (i <= 6) ? 0 : 5);
      end
    end
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_load_priority();
    bus.load = 1'b1;
    bus.load_value = 3'd1;
    @(negedge clk);
    bus.load_value = 3'd7;
    @(negedge clk);
    bus.load = 1'b0;
    checks++;
    if (bus.count !== 3'd5) begin
      failures++;
      $display("FAIL load_clamp actual=%0d required=5", bus.count);
    end
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.load = (i == 6);
      bus.load_value = 3'd2;
      if (i >= 7) begin
        checks++;
        if (bus.count !== 3'd2 || bus.borrow !== 1'b0) begin
          failures++;
          $display("FAIL load_priority cycle=%0d actual count=%0d borrow=%b required 2/0", i, bus.count, bus.borrow);
        end
      end
    end
    bus.load = 1'b0;
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_press();
    bus.step_btn = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd5 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL mid_press_reset actual count=%0d pulse=%b required 5/0", bus.count, bus.step_pulse);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.step_pulse !== (i == 6) || bus.count !== ((i <= 6) ? 3'd5 : 3'd4)) begin
        failures++;
        $display("FAIL requalify cycle=%0d actual pulse=%b count=%0d required pulse=%b count=%0d",
                 i, bus.step_pulse, bus.count, (i == 6), (i <= 6) ? 5 : 4);
      end
    end
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (int'(bus.count) != m_count || int'(bus.borrow) != m_borrow ||
          int'(bus.step_pulse) != m_pulse || int'(bus.zero) != int'(m_count == 0)) begin
        failures++;
        $display("FAIL random cycle=%0d actual count=%0d borrow=%b pulse=%b zero=%b required count=%0d borrow=%0d pulse=%0d",
                 i, bus.count, bus.borrow, bus.step_pulse, bus.zero, m_count, m_borrow, m_pulse);
      end
      if ($urandom_range(7) == 0) bus.step_btn = ~bus.step_btn;
      bus.load       = ($urandom_range(24) == 0);
      bus.load_value = W'($urandom_range(7));
    end
    bus.load = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    bus.step_btn   = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_load_priority();
    test_reset_mid_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
